// File: rtl/ram_arb_pkg.sv
// Shared FSM encoding, default RAM geometry and grant helper for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam int DEF_ADDR_SIZE = 10;
  localparam int DEF_WORD_SIZE = 8;

  function automatic logic [1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request always wins; on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner,
  output logic       o_valid
);

  assign o_valid  = |i_req;
  assign o_winner = (i_req == 2'b11) ? ~i_last : i_req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two requesters: grant at the IDLE edge, one ACCESS cycle, one-cycle ack in DONE.
// Request-to-ack is 2 cycles and one access completes every 3 cycles; requesters hold their request until ack.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int WORD_SIZE = DEF_WORD_SIZE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req,
  input  logic [1:0]             req_wr,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*WORD_SIZE-1:0] req_wdata,
  output logic [1:0]             ack,
  output logic [WORD_SIZE-1:0]   rdata,
  output logic [ADDR_SIZE-1:0]   ram_addr,
  output logic [WORD_SIZE-1:0]   ram_din,
  output logic                   ram_wr,
  output logic                   ram_cs,
  input  logic [WORD_SIZE-1:0]   ram_dout
);

  arb_state_e           r_state;
  logic                 r_last;
  logic                 r_winner;
  logic [1:0]           r_ack;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [ADDR_SIZE-1:0] r_ram_addr;
  logic [WORD_SIZE-1:0] r_ram_din;
  logic                 r_ram_wr;
  logic                 r_ram_cs;

  logic                 w_winner;
  logic                 w_valid;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [WORD_SIZE-1:0] w_wdata;

  rr_arb2 u_rr_arb2 (
    .i_req    (req),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  assign w_addr  = w_winner ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
  assign w_wdata = w_winner ? req_wdata[2*WORD_SIZE-1:WORD_SIZE] : req_wdata[WORD_SIZE-1:0];

  // r_ram_wr doubles as the latched direction: it is still valid on the ACCESS->DONE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_winner   <= 1'b0;
      r_ack      <= 2'b00;
      r_rdata    <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_wr   <= 1'b0;
      r_ram_cs   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= 2'b00;
          if (w_valid) begin
            r_winner   <= w_winner;
            r_ram_cs   <= 1'b1;
            r_ram_wr   <= req_wr[w_winner];
            r_ram_addr <= w_addr;
            r_ram_din  <= w_wdata;
            r_state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!r_ram_wr) begin
            r_rdata <= ram_dout;
          end
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          r_ack    <= grant_onehot(r_winner);
          r_state  <= DONE;
        end
        DONE: begin
          r_ack   <= 2'b00;
          r_last  <= r_winner;
          r_state <= IDLE;
        end
        default: begin
          r_ack    <= 2'b00;
          r_ram_cs <= 1'b0;
          r_ram_wr <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign rdata    = r_rdata;
  assign ram_addr = r_ram_addr;
  assign ram_din  = r_ram_din;
  assign ram_wr   = r_ram_wr;
  assign ram_cs   = r_ram_cs;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-timeline model compared every cycle plus directed literal checks.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [1:0]      req_wr = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      ack;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din;
  logic            ram_wr;
  logic            ram_cs;
  wire  [DW-1:0]   ram_dout;

  int n_chk = 0;
  int n_err = 0;

  ram_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wr    (ram_wr),
    .ram_cs    (ram_cs),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Environment RAM: combinational read, Z when not reading, write on the clock edge.
  logic [DW-1:0] ram_mem [1<<AW];
  logic [DW-1:0] exp_mem [1<<AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = DW'(i) ^ 8'h3C;
      exp_mem[i] = DW'(i) ^ 8'h3C;
    end
  end
  assign ram_dout = (ram_cs && !ram_wr) ? ram_mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) if (ram_cs && ram_wr) ram_mem[ram_addr] <= ram_din;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each granted transaction occupies cycle m_acc (RAM access) and m_acc+1 (ack);
  // the next grant may happen no earlier than the edge starting cycle m_acc+3.
  int            cyc = 0;
  int            m_acc = -100;
  logic          m_last = 1'b1;
  logic          m_win = 1'b0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  logic [DW-1:0] m_rdata = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc   = -100;
      m_last  = 1'b1;
      m_rdata = '0;
    end else begin
      cyc++;
      if (m_acc == cyc - 1) begin
        if (m_wr) exp_mem[m_addr] = m_din;
        else      m_rdata = exp_mem[m_addr];
      end
      if (m_acc == cyc - 2) m_last = m_win;
      if (cyc >= m_acc + 3 && req != 2'b00) begin
        m_win  = (req == 2'b11) ? ~m_last : req[1];
        m_wr   = req_wr[m_win];
        m_addr = m_win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        m_din  = m_win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
        m_acc  = cyc;
      end
    end
  end

  logic prev_cs = 1'b0;
  always @(negedge clk) begin
    logic       e_cs;
    logic [1:0] e_ack;
    e_cs  = (m_acc == cyc);
    e_ack = (m_acc == cyc - 1) ? (m_win ? 2'b10 : 2'b01) : 2'b00;
    check("m_cs", ram_cs, e_cs);
    check("m_ack", ack, e_ack);
    if (e_cs) begin
      check("m_wr", ram_wr, m_wr);
      check("m_addr", ram_addr, m_addr);
      check("m_din", ram_din, m_din);
    end
    if (e_ack != 2'b00 && !m_wr) check("m_rdata", rdata, m_rdata);
    check("inv_ack_onehot", $countones(ack) <= 1, 1);
    check("inv_wr_needs_cs", ram_wr && !ram_cs, 0);
    check("inv_cs_back2back", ram_cs && prev_cs, 0);
    prev_cs = ram_cs;
  end

  task automatic do_access(input logic [1:0] r, input logic [1:0] w,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           output logic [1:0] g_ack, output logic [DW-1:0] g_rdata,
                           output logic g_wr, output logic [AW-1:0] g_addr,
                           output logic [DW-1:0] g_din, output int g_n);
    @(negedge clk); #1;
    req = r; req_wr = w; req_addr = {a1, a0}; req_wdata = {d1, d0};
    g_ack = 2'b00; g_rdata = '0; g_wr = 1'b0; g_addr = '0; g_din = '0; g_n = 0;
    for (int i = 1; i <= 8 && g_ack == 2'b00; i++) begin
      @(negedge clk);
      if (ram_cs) begin g_wr = ram_wr; g_addr = ram_addr; g_din = ram_din; end
      if (ack != 2'b00) begin g_ack = ack; g_rdata = rdata; g_n = i; end
    end
    check("ack_within_budget", g_ack != 2'b00, 1);
    #1;
    req = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]    g_ack;
    logic [DW-1:0] g_rdata;
    logic          g_wr;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_din;
    int            g_n;
    logic [1:0]    e_tie;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ack", ack, 2'b00);
    check("rst_cs", ram_cs, 1'b0);
    check("rst_wr", ram_wr, 1'b0);
    check("rst_addr", ram_addr, 10'h000);
    check("rst_din", ram_din, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    #1; rst_n = 1'b1;

    // Single write by requester 0
    do_access(2'b01, 2'b01, 10'h005, 10'h000, 8'hA5, 8'h00, g_ack, g_rdata, g_wr, g_addr, g_din, g_n);
    check("wr_ack", g_ack, 2'b01);
    check("wr_lat", g_n, 2);
    check("wr_ramwr", g_wr, 1'b1);
    check("wr_addr", g_addr, 10'h005);
    check("wr_din", g_din, 8'hA5);

    // Read-back by requester 1
    do_access(2'b10, 2'b00, 10'h000, 10'h005, 8'h00, 8'h00, g_ack, g_rdata, g_wr, g_addr, g_din, g_n);
    check("rd_ack", g_ack, 2'b10);
    check("rd_lat", g_n, 2);
    check("rd_ramwr", g_wr, 1'b0);
    check("rd_addr", g_addr, 10'h005);
    check("rd_data", g_rdata, 8'hA5);

    // Lone request from the last winner is still granted
    do_access(2'b10, 2'b10, 10'h000, 10'h007, 8'h00, 8'h77, g_ack, g_rdata, g_wr, g_addr, g_din, g_n);
    check("solo_ack", g_ack, 2'b10);
    check("solo_addr", g_addr, 10'h007);
    check("solo_din", g_din, 8'h77);

    // Tie after reset, requests held: 01,10,01,10 every 3 cycles
    @(negedge clk); #1; rst_n = 1'b0;
    @(negedge clk); #1; rst_n = 1'b1;
    req = 2'b11; req_wr = 2'b00; req_addr = {10'h006, 10'h005}; req_wdata = '0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      e_tie = (i % 3 == 2) ? (((i / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check("tie_ack", ack, e_tie);
    end
    #1; req = 2'b00;

    // Request dropped during ACCESS still completes
    @(negedge clk); #1;
    req = 2'b01; req_wr = 2'b00; req_addr = {10'h000, 10'h006};
    @(negedge clk);
    check("abandon_cs", ram_cs, 1'b1);
    #1; req = 2'b00;
    @(negedge clk);
    check("abandon_ack", ack, 2'b01);
    check("abandon_rdata", rdata, 8'h3A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abandon_idle_cs", ram_cs, 1'b0);
      check("abandon_idle_ack", ack, 2'b00);
    end

    // Reset during ACCESS of a write to the top address
    @(negedge clk); #1;
    req = 2'b01; req_wr = 2'b01; req_addr = {10'h000, 10'h3FF}; req_wdata = {8'h00, 8'h5A};
    @(negedge clk);
    check("rmid_cs", ram_cs, 1'b1);
    check("rmid_wr", ram_wr, 1'b1);
    check("rmid_addr", ram_addr, 10'h3FF);
    #1; rst_n = 1'b0; req = 2'b00;
    #1;
    check("rmid_cs_now", ram_cs, 1'b0);
    check("rmid_ack_now", ack, 2'b00);
    check("rmid_wr_now", ram_wr, 1'b0);
    @(negedge clk);
    check("rmid_ack_held", ack, 2'b00);
    #1; rst_n = 1'b1;
    req = 2'b11; req_wr = 2'b00; req_addr = {10'h005, 10'h006};
    @(negedge clk);
    check("rmid_tie_cs", ram_cs, 1'b1);
    @(negedge clk);
    check("rmid_tie_ack", ack, 2'b01);
    check("rmid_tie_rdata", rdata, 8'h3A);
    #1; req = 2'b00;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 10, RAM address width.
REQ-002 SHALL have parameter WORD_SIZE, default 8, RAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  2  per-requester access request; bit i = requester i.
REQ-006 SHALL have port req_wr  input  2  per-requester direction: 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  2*ADDR_SIZE  requester i address in bits [i*ADDR_SIZE +: ADDR_SIZE].
REQ-008 SHALL have port req_wdata  input  2*WORD_SIZE  requester i write data in bits [i*WORD_SIZE +: WORD_SIZE].
REQ-009 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-010 SHALL have port rdata  output  WORD_SIZE  read data; valid only in the cycle ack has a bit set for a read.
REQ-011 SHALL have port ram_addr  output  ADDR_SIZE  RAM address.
REQ-012 SHALL have port ram_din  output  WORD_SIZE  RAM write data.
REQ-013 SHALL have port ram_wr  output  1  RAM write enable (1 = write, 0 = read).
REQ-014 SHALL have port ram_cs  output  1  RAM chip select.
REQ-015 SHALL have port ram_dout  input  WORD_SIZE  RAM read data; combinational and tri-stated (Z) while ram_cs = 0 or ram_wr = 1.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACCESS, DONE.
REQ-017 In IDLE with req != 0 at a rising edge, SHALL latch winner index, direction, address and write data into registers and go to ACCESS.
REQ-018 In IDLE with req = 0, SHALL remain in IDLE; ram_cs = 0, ack = 0.
REQ-019 Tie (req = 2'b11) SHALL be resolved round-robin: grant the requester not granted last; a single request SHALL always be granted regardless of history.
REQ-020 In ACCESS (exactly one cycle), ram_cs = 1, ram_wr = latched direction, ram_addr and ram_din = latched values; next state DONE.
REQ-021 On the ACCESS->DONE edge, a read SHALL capture ram_dout into the rdata register; a write SHALL leave rdata unchanged.
REQ-022 In DONE (exactly one cycle), ack[winner] = 1, ram_cs = 0; next state IDLE; the last-granted pointer SHALL update to the winner.
REQ-023 Latency: request sampled at edge k -> ACCESS during cycle k..k+1 -> ack high during cycle k+1..k+2; throughput one access per 3 cycles.
REQ-024 Requesters SHALL hold req, req_wr, req_addr, req_wdata stable until ack; the arbiter SHALL sample them only at the IDLE edge.
REQ-025 A req deasserted after grant SHALL NOT abort the access; ack is still issued.
REQ-026 A req still high in the cycle ack is pulsed SHALL be treated as a new request at the next IDLE edge.
REQ-027 ram_cs and ram_wr SHALL be driven from registered state only (glitch-free); ram_wr SHALL be 0 whenever ram_cs = 0.
REQ-028 ack SHALL never have more than one bit set.

Reset
REQ-029 On rst_n = 0, immediately: state = IDLE, ack = 0, ram_cs = 0, ram_wr = 0, ram_addr = 0, ram_din = 0, rdata = 0.
REQ-030 Last-granted pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-031 Reset asserted during ACCESS or DONE SHALL abort the transaction with no ack; a write in progress may or may not have reached the RAM.

Structure
REQ-032 A shared package ram_arb_pkg SHALL hold the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and default ADDR_SIZE / WORD_SIZE constants.
REQ-033 The tie-breaking logic SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output winner index, valid), instantiated once.

Verification
REQ-034 Single write: req=01, req_wr=01, addr0=10'h005, wdata0=8'hA5 -> one cycle ram_cs=1/ram_wr=1/ram_addr=5/ram_din=A5, then ack=01.
REQ-035 Read-back: requester 1 reads addr 10'h005 after REQ-034 -> ack=10 with rdata=8'hA5 exactly 2 cycles after the sampling edge.
REQ-036 Tie after reset: req=11 held continuously -> grants alternate 0,1,0,1; ack pattern 01,10,01,10 every 3 cycles.
REQ-037 Abandon: req0 raised then dropped during ACCESS -> access completes, ack=01 still pulsed, FSM returns to IDLE.
REQ-038 Reset mid-op: rst_n low during ACCESS of a write to 10'h3FF -> ram_cs=0 and ack=0 in the same cycle; pointer=1; next tie grants requester 0.
REQ-039 Checkers throughout: ack one-hot-or-zero, ram_wr=0 when ram_cs=0, no ram_cs=1 in two consecutive cycles.
